// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module  : inst_fetch_pkg
// Purpose : Shared constants, IF/ID record type and alignment helper for the
//           instruction fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    // Fetch addresses are always word aligned; misaligned low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : inst_fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch_pc_reg.sv
// ============================================================================
// Module  : inst_fetch_pc_reg
// Purpose : Program counter register with reset/branch/hold/advance priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    input  logic        i_hold,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_target
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [1:0]  w_unused_misalign;

    assign w_pc_plus4        = r_pc + PC_STEP;
    assign w_target          = {i_branch_addr[31:2], 2'b00};
    assign w_unused_misalign = i_branch_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_branch_taken) begin
            r_pc <= w_target;
        end else if (!i_hold) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_target   = w_target;

endmodule : inst_fetch_pc_reg

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module  : inst_fetch_unit
// Purpose : Fetch stage top: PC sub-module, IF/ID pipeline register and the
//           optional end-of-memory halt (macro FETCH_BOUNDS_CHECK_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 188,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_in,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        halted
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_halt_active;
    if_id_t      r_ifid;

    inst_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .i_branch_taken (branch_taken),
        .i_branch_addr  (branch_addr),
        .i_hold         (freeze | w_halt_active),
        .o_pc           (w_pc),
        .o_pc_plus4     (w_pc_plus4),
        .o_target       (w_target)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_halted;

    // Halt is sticky; only a branch back into memory (or reset) releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (branch_taken) begin
            r_halted <= r_halted & (w_target >= MEM_BYTES);
        end else if (!r_halted && !freeze && (w_pc_plus4 >= MEM_BYTES)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halt_active = r_halted;
`else
    logic w_unused_mem_bytes;
    logic [31:0] w_unused_target;

    assign w_halt_active      = 1'b0;
    assign w_unused_mem_bytes = ^MEM_BYTES;
    assign w_unused_target    = w_target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid <= '{pc: 32'h0, inst: NOP_WORD, valid: 1'b0};
        end else if (branch_taken || w_halt_active) begin
            // Flush keeps the PC+4 of the squashed fetch for debug visibility.
            r_ifid <= '{pc: w_pc_plus4, inst: NOP_WORD, valid: 1'b0};
        end else if (!freeze) begin
            r_ifid <= '{pc: w_pc_plus4, inst: inst_in, valid: 1'b1};
        end
    end

    assign pc_out   = w_pc;
    assign if_pc    = r_ifid.pc;
    assign if_inst  = r_ifid.inst;
    assign if_valid = r_ifid.valid;
    assign halted   = w_halt_active;

endmodule : inst_fetch_unit

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module  : tb_inst_fetch_unit
// Purpose : Self-checking bench for inst_fetch_unit against a step model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned MEMB   = 188;
    localparam logic [31:0] NOP    = 32'hE000_0000;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    // Memory: in-range words equal their byte address, out of range reads NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < MEMB) ? a : NOP;
    endfunction

    assign inst_in = mem_word(pc_out);

    inst_fetch_unit #(
        .RESET_PC  (RST_PC),
        .MEM_BYTES (MEMB),
        .NOP_WORD  (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc_out       (pc_out),
        .inst_in      (inst_in),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, compare.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        logic [31:0] fetch_word, seq, tgt;
        rst = r; freeze = f; branch_taken = b; branch_addr = a;
        fetch_word = mem_word(m_pc);
        seq = m_pc + 32'd4;
        tgt = a & 32'hFFFF_FFFC;
        if (r) begin
            m_pc = RST_PC; m_ifpc = 0; m_inst = NOP; m_valid = 0; m_halted = 0;
        end else if (b) begin
            m_ifpc = seq; m_inst = NOP; m_valid = 0;
            m_halted = BC && m_halted && (tgt >= MEMB);
            m_pc = tgt;
        end else if (m_halted) begin
            m_ifpc = seq; m_inst = NOP; m_valid = 0;
        end else if (!f) begin
            m_ifpc = seq; m_inst = fetch_word; m_valid = 1;
            m_pc = seq;
            if (BC && seq >= MEMB) m_halted = 1;
        end
        @(posedge clk);
        #1;
        check("pc_out",   pc_out,   m_pc);
        check("if_pc",    if_pc,    m_ifpc);
        check("if_inst",  if_inst,  m_inst);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        check("halted",   {31'b0, halted},   {31'b0, m_halted});
    endtask

    initial begin
        m_pc = 0; m_ifpc = 0; m_inst = 0; m_valid = 0; m_halted = 0;
        @(negedge clk);

        // Reset held two cycles, then sequential fetch 0,4,8,12,16
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // Branch to misaligned 0x42 from pc 16, then fetch at 0x40
        step(0, 0, 1, 32'h0000_0042);
        repeat (2) step(0, 0, 0, 0);

        // Freeze for 3 cycles at pc 8
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Branch with freeze wins; reset overrides branch
        step(0, 1, 1, 32'h0000_0020);
        step(0, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0080);
        step(0, 0, 0, 0);

        // Wrap from the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (2) step(0, 0, 0, 0);

        // Run off the end of memory, then recover with a branch to 0
        step(0, 0, 1, 32'd180);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'd200);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'd0);
        repeat (2) step(0, 0, 0, 0);

        // Randomised mix of events
        for (int i = 0; i < 400; i++) begin
            logic r, f, b;
            logic [31:0] a;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 12);
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(r, f, b, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_unit

`default_nettype wire

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage: owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. It is the initiator side of the `pc_in`/`inst_out` memory interface. It sits between the hazard unit and EXE-stage branch resolution on one side and the ID stage on the other.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MEM_BYTES`, 188, size of the instruction memory in bytes. Used only when bounds checking is compiled in.
- `NOP_WORD`, 32'hE000_0000, bubble instruction; equals the memory's out-of-range word.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `freeze` in 1: hazard stall; holds PC and IF/ID.
- `branch_taken` in 1: redirect from EXE.
- `branch_addr` in 32: redirect target (byte address).
- `pc_out` out 32: fetch address to instruction memory `pc_in`.
- `inst_in` in 32: word from instruction memory `inst_out`, valid in the same cycle.
- `if_pc` out 32: registered PC+4 of the captured instruction.
- `if_inst` out 32: registered instruction.
- `if_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: fetch stopped past end of memory (bounds checking only).

## Operation
- `pc_out` is the PC register, driven directly with no combinational path from inputs.
- The next PC is chosen in strict priority order:
  - `rst` loads `RESET_PC`.
  - `branch_taken` loads `{branch_addr[31:2],2'b00}`. Misaligned low bits are dropped.
  - `freeze` holds the PC.
  - Otherwise PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID register uses the same priority:
  - `rst`: `if_inst`=`NOP_WORD`, `if_pc`=0, `if_valid`=0.
  - `branch_taken`: flush. `if_inst`=`NOP_WORD`, `if_valid`=0, and `if_pc` takes the PC+4 of the flushed fetch.
  - `freeze`: hold all three.
  - Otherwise: `if_inst`=`inst_in`, `if_pc`=PC+4, `if_valid`=1.
- `branch_taken` together with `freeze`: the branch wins. The PC is redirected and IF/ID is flushed, not held.
- `rst` asserted mid-stream overrides everything on that edge, including a pending branch.

## Timing
- Reset values:
  - `pc_out`=`RESET_PC`
  - `if_pc`=0
  - `if_inst`=`NOP_WORD`
  - `if_valid`=0
  - `halted`=0
- Fetch latency is 1 cycle. The word at `pc_out`=A during cycle n appears on `if_inst` in cycle n+1, with `if_pc`=A+4.
- Branch asserted in cycle n:
  - `pc_out`=target in n+1.
  - `if_valid`=0 in n+1.
  - Target word on `if_inst` in n+2.
- Freeze asserted for k cycles: all outputs are frozen for exactly those k cycles, and fetch resumes at the held PC.
- No internal state beyond the PC, the IF/ID register and `halted`.

## Configuration
- Macro `FETCH_BOUNDS_CHECK_EN`.
- Defined:
  - The first non-branch, non-frozen update that would fetch with `pc_out` ≥ `MEM_BYTES` sets sticky `halted`=1.
  - While halted: the PC holds, IF/ID captures `NOP_WORD` with `if_valid`=0, and `freeze` is irrelevant.
  - Cleared only by `rst` or by `branch_taken` with a target < `MEM_BYTES`. A branch to an out-of-range target keeps `halted`=1.
- Undefined:
  - `halted` is tied 0.
  - The PC advances freely, and the memory's `NOP_WORD` is captured with `if_valid`=1.

## Structure
- Package `inst_fetch_pkg` holds:
  - `NOP_WORD_DEFAULT` (32'hE000_0000)
  - `PC_STEP` (4)
  - the `if_id_t` struct {pc, inst, valid}
- Sub-module `inst_fetch_pc_reg` contains the PC register, next-PC priority mux and word alignment.
- The top level holds the IF/ID register and the halt logic.

## Test plan
- Reset sequence: hold `rst` 2 cycles, then release with memory returning word = address → `pc_out` 0,4,8,12; `if_inst`=0,4,8 lagging one cycle; `if_pc`=4,8,12; `if_valid` 0 then 1.
- Branch: `branch_taken`=1 with `branch_addr`=32'h0000_0042 while `pc_out`=16 → next `pc_out`=32'h40; `if_valid`=0 for one cycle; then `if_inst`=word@0x40 with `if_pc`=0x44.
- Freeze: assert 3 cycles at `pc_out`=8 → `pc_out`, `if_inst` and `if_pc` constant for 3 cycles; fetch resumes at 8.
- Simultaneous events:
  - `freeze`=1 and `branch_taken`=1 with target 0x20 → `pc_out`=0x20, IF/ID flushed.
  - `rst` together with a branch → `pc_out`=`RESET_PC`.
- Wrap: load PC 32'hFFFF_FFFC via branch (macro off) → next `pc_out`=0.
- `FETCH_BOUNDS_CHECK_EN`, `MEM_BYTES`=188:
  - Run from 180 → `halted`=1 when advancing to 188; PC holds at 188; `if_valid`=0.
  - Branch to 0 → `halted`=0, fetch resumes.
